sysbus_arbiter: RTL and testbench
=================================

// Module: sysbus_arbiter
// PURPOSE
//  Shares the single Sysbus master port between the instruction-fetch unit (requester 0) and the
//  data load/store unit (requester 1). Grants one cache-line transaction at a time, drives the
//  Sysbus request/tag handshake, streams write beats, and steers read response beats to the owner.
//  It sits between Core's fetch/data front-ends and the Sysbus interface.
// PARAMETERS
//  BEATS      8    64-bit beats per line transaction (64B line)
//  TAG_W      13   Sysbus tag width: [12]=WRITE(1)/READ(0), [11:8]=MEMORY=4'h1, [7:0]=requester id
//  DATA_PRIO  0    0: round-robin between requesters; 1: requester 1 always wins ties
// PORTS
//  clk            in   1       clock (Sysbus clk)
//  reset_n        in   1       asynchronous, active-low reset
//  req_valid      in   2       per-requester line request; held until req_ready
//  req_addr       in   2x64    per-requester address; bits [5:0] ignored, sent as addr & ~63
//  req_write      in   2       1 = line write, 0 = line read
//  req_ready      out  2       one-cycle pulse: request accepted (granted)
//  wdata          in   2x64    write beat from owner, consumed on wdata_ready
//  wdata_ready    out  2       one-cycle pulse per write beat taken from owner
//  resp_valid     out  2       read beat valid for that requester
//  resp_data      out  64      read beat data (shared; qualified by resp_valid)
//  err_unexpected out  1       sticky: stray/mis-tagged/short response seen
//  bus_reqcyc     out  1       Sysbus reqcyc
//  bus_req        out  64      Sysbus req (address cycle, then write beats)
//  bus_reqtag     out  TAG_W   Sysbus reqtag
//  bus_reqack     in   1       Sysbus reqack
//  bus_respcyc    in   1       Sysbus respcyc
//  bus_resp       in   64      Sysbus resp
//  bus_resptag    in   TAG_W   Sysbus resptag
//  bus_respack    out  1       Sysbus respack
// BEHAVIOUR
//  Reset (reset_n low, any cycle incl. mid-transaction): state=IDLE, rr_ptr=0, beat count 0;
//   req_ready, wdata_ready, resp_valid, bus_reqcyc, err_unexpected = 0; bus_req, bus_reqtag, resp_data = 0.
//  bus_respack = bus_respcyc combinationally, in every state (always able to accept).
//  States: IDLE -> ADDR -> (RWAIT -> RDATA | WDATA) -> IDLE.
//  IDLE: if any req_valid, pick winner (both valid: DATA_PRIO=1 -> req 1; else req != last grant,
//   rr_ptr starts at 0). Pulse req_ready[win]; latch owner, write, addr; next cycle ADDR. 1-cycle latency.
//  ADDR: bus_reqcyc=1, bus_req=addr & ~63, bus_reqtag={write,4'h1,8'(owner)}, held stable until
//   the cycle bus_reqack=1; then reqcyc drops next cycle; go WDATA if write else RWAIT. rr_ptr updates here.
//  WDATA: BEATS consecutive cycles, bus_req=wdata[owner], wdata_ready[owner] pulsed in the same cycle
//   (owner must present beat combinationally-valid); after beat BEATS-1 -> IDLE. No response expected.
//  RWAIT: wait for bus_respcyc with resptag[7:0]==owner and [12]==0 -> RDATA, that beat forwarded.
//  RDATA: each respcyc cycle: resp_valid[owner]=1, resp_data=bus_resp (registered, 1-cycle latency).
//   Beat BEATS-1 -> IDLE. respcyc low before BEATS beats -> IDLE, set err_unexpected.
//  Stray response (respcyc in IDLE/ADDR/WDATA, or tag mismatch in RWAIT): acked, dropped, err set.
//  resp_valid never asserts for the non-owner; never both bits set. Beat counter is 3 bits
//   (log2 BEATS), wraps only on transaction end. New request accepted the cycle after return to IDLE.
//  Simultaneous reqack and respcyc in ADDR: ack processed, response treated as stray.
// TESTING
//  Req0 read 0x1008 alone -> req_ready[0] pulse 1 cycle later, bus_req=0x1000, tag=0x0100; 8 beats
//   0xA0..0xA7 -> resp_valid[0] x8 with same data, resp_valid[1] stays 0.
//  Req0 and req1 both valid every cycle, DATA_PRIO=0 -> grants alternate 0,1,0,1; DATA_PRIO=1 -> always 1.
//  Req1 write 0x2040 data 0xD0..0xD7 -> tag=0x1101, bus_req=0x2040 then beats 0xD0..0xD7, 8 wdata_ready pulses.
//  reqack delayed 5 cycles -> bus_reqcyc, bus_req, bus_reqtag constant for 6 cycles, no duplicate grant.
//  respcyc in IDLE / resptag id 1 while owner 0 / respcyc drops after 3 beats -> respack=1, data dropped, err_unexpected=1.
//  reset_n low during RDATA beat 4 -> all outputs 0 immediately; after release, fresh req0 read completes normally.

Source files
------------

// File: rtl/sysbus_arbiter.sv
// Two-requester Sysbus master arbiter: grants one cache-line transaction at a time,
// drives the request/tag handshake, streams write beats and steers read beats to the owner.
module sysbus_arbiter #(
  parameter int BEATS     = 8,
  parameter int TAG_W     = 13,
  parameter bit DATA_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       req_valid,
  input  logic [127:0]     req_addr,
  input  logic [1:0]       req_write,
  output logic [1:0]       req_ready,
  input  logic [127:0]     wdata,
  output logic [1:0]       wdata_ready,
  output logic [1:0]       resp_valid,
  output logic [63:0]      resp_data,
  output logic             err_unexpected,
  output logic             bus_reqcyc,
  output logic [63:0]      bus_req,
  output logic [TAG_W-1:0] bus_reqtag,
  input  logic             bus_reqack,
  input  logic             bus_respcyc,
  input  logic [63:0]      bus_resp,
  input  logic [TAG_W-1:0] bus_resptag,
  output logic             bus_respack,
  output logic [2:0]       dbg_state
);
  // Handshake: a requester holds req_valid until it sees the one-cycle req_ready pulse;
  // Sysbus address/tag stay stable while bus_reqcyc=1 until the cycle bus_reqack=1.
  localparam int CW = $clog2(BEATS);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_RWAIT, S_RDATA} state_t;

  state_t        state_q, state_d;
  logic          owner_q;
  logic          write_q;
  logic [63:0]   addr_q;
  logic [CW-1:0] cnt_q;
  logic          rr_ptr_q;
  logic [1:0]    req_ready_q;
  logic [1:0]    resp_valid_q;
  logic [63:0]   resp_data_q;
  logic          err_q;

  logic             win;
  logic             last_beat;
  logic             tag_ok;
  logic [1:0]       owner_onehot;
  logic [TAG_W-1:0] tag;

  // Round-robin tie goes to the requester that was not granted last.
  always_comb begin
    win = req_valid[1];
    if (req_valid == 2'b11) win = DATA_PRIO ? 1'b1 : ~rr_ptr_q;
  end

  assign last_beat    = (cnt_q == CW'(BEATS - 1));
  assign owner_onehot = owner_q ? 2'b10 : 2'b01;
  assign tag          = TAG_W'({write_q, 4'h1, 7'd0, owner_q});
  assign tag_ok       = (bus_resptag == TAG_W'({1'b0, 4'h1, 7'd0, owner_q}));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (|req_valid) state_d = S_ADDR;
      S_ADDR:  if (bus_reqack) state_d = write_q ? S_WDATA : S_RWAIT;
      S_WDATA: if (last_beat) state_d = S_IDLE;
      S_RWAIT: if (bus_respcyc && tag_ok) state_d = S_RDATA;
      S_RDATA: if (!bus_respcyc || last_beat) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus_respack = bus_respcyc;
    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    wdata_ready = '0;
    if (state_q == S_ADDR) begin
      bus_reqcyc = 1'b1;
      bus_req    = addr_q & ~64'd63;
      bus_reqtag = tag;
    end else if (state_q == S_WDATA) begin
      bus_req     = owner_q ? wdata[127:64] : wdata[63:0];
      wdata_ready = owner_onehot;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      cnt_q        <= '0;
      rr_ptr_q     <= 1'b0;
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (|req_valid) begin
            owner_q     <= win;
            write_q     <= req_write[win];
            addr_q      <= win ? req_addr[127:64] : req_addr[63:0];
            req_ready_q <= win ? 2'b10 : 2'b01;
          end
          if (bus_respcyc) err_q <= 1'b1;
        end
        S_ADDR: begin
          if (bus_reqack) rr_ptr_q <= owner_q;
          if (bus_respcyc) err_q <= 1'b1;
        end
        S_WDATA: begin
          cnt_q <= last_beat ? '0 : cnt_q + 1'b1;
          if (bus_respcyc) err_q <= 1'b1;
        end
        S_RWAIT: begin
          if (bus_respcyc) begin
            if (tag_ok) begin
              resp_valid_q <= owner_onehot;
              resp_data_q  <= bus_resp;
              cnt_q        <= cnt_q + 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_RDATA: begin
          if (bus_respcyc) begin
            resp_valid_q <= owner_onehot;
            resp_data_q  <= bus_resp;
            cnt_q        <= last_beat ? '0 : cnt_q + 1'b1;
          end else begin
            err_q <= 1'b1;
            cnt_q <= '0;
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_data      = resp_data_q;
  assign err_unexpected = err_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter: a round-robin instance under full check plus a
// DATA_PRIO=1 instance sharing its inputs for the tie-break comparison.
module tb_sysbus_arbiter;
  logic         clk = 1'b0;
  logic         reset_n;
  logic [1:0]   req_valid;
  logic [127:0] req_addr;
  logic [1:0]   req_write;
  logic [127:0] wdata;
  logic         bus_reqack;
  logic         bus_respcyc;
  logic [63:0]  bus_resp;
  logic [12:0]  bus_resptag;

  logic [1:0]  req_ready, wdata_ready, resp_valid;
  logic [63:0] resp_data, bus_req;
  logic        err_unexpected, bus_reqcyc, bus_respack;
  logic [12:0] bus_reqtag;
  logic [2:0]  dbg_state;

  logic [1:0]  req_ready_p, wdata_ready_p, resp_valid_p;
  logic [63:0] resp_data_p, bus_req_p;
  logic        err_p, bus_reqcyc_p, bus_respack_p;
  logic [12:0] bus_reqtag_p;
  logic [2:0]  dbg_state_p;

  int n_tests = 0;
  int n_fail  = 0;
  int k;

  always #5 clk = ~clk;

  sysbus_arbiter #(.BEATS(8), .TAG_W(13), .DATA_PRIO(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_write(req_write), .req_ready(req_ready), .wdata(wdata), .wdata_ready(wdata_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .err_unexpected(err_unexpected),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
    .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
    .bus_resptag(bus_resptag), .bus_respack(bus_respack), .dbg_state(dbg_state)
  );

  sysbus_arbiter #(.BEATS(8), .TAG_W(13), .DATA_PRIO(1'b1)) dut_prio (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_write(req_write), .req_ready(req_ready_p), .wdata(wdata), .wdata_ready(wdata_ready_p),
    .resp_valid(resp_valid_p), .resp_data(resp_data_p), .err_unexpected(err_p),
    .bus_reqcyc(bus_reqcyc_p), .bus_req(bus_req_p), .bus_reqtag(bus_reqtag_p),
    .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
    .bus_resptag(bus_resptag), .bus_respack(bus_respack_p), .dbg_state(dbg_state_p)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    req_valid = '0; req_addr = '0; req_write = '0; wdata = '0;
    bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
    reset_n = 1'b0;
    tick;
    tick;
    reset_n = 1'b1;
    tick;
  endtask

  // Requester 0 reads one line; beats are base, base+1, ... base+7.
  task automatic read_line(input logic [63:0] addr, input logic [63:0] line, input logic [63:0] base);
    req_valid = 2'b01; req_addr[63:0] = addr; req_write = 2'b00;
    #1 chk("rd_ready_latency", req_ready, 2'b00);
    tick;
    chk("rd_ready", req_ready, 2'b01);
    chk("rd_reqcyc", bus_reqcyc, 1);
    chk("rd_addr", bus_req, line);
    chk("rd_tag", bus_reqtag, 13'h0100);
    req_valid = 2'b00; bus_reqack = 1'b1;
    tick;
    bus_reqack = 1'b0;
    chk("rd_reqcyc_drop", bus_reqcyc, 0);
    bus_respcyc = 1'b1; bus_resptag = 13'h0100;
    for (int i = 0; i < 8; i++) begin
      bus_resp = base + 64'(i);
      #1 chk("rd_respack", bus_respack, 1);
      tick;
      chk("rd_valid", resp_valid, 2'b01);
      chk("rd_data", resp_data, base + 64'(i));
    end
    bus_respcyc = 1'b0;
    chk("rd_back_idle", dbg_state, 0);
    tick;
    chk("rd_valid_off", resp_valid, 2'b00);
    chk("rd_no_err", err_unexpected, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = '0; req_addr = '0; req_write = '0; wdata = '0;
    bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
    reset_n = 1'b0;
    tick;
    tick;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_reqcyc", bus_reqcyc, 0);
    chk("rst_req", bus_req, 0);
    chk("rst_reqtag", bus_reqtag, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_err", err_unexpected, 0);
    chk("rst_state", dbg_state, 0);
    reset_n = 1'b1;
    tick;

    read_line(64'h1008, 64'h1000, 64'hA0);

    // Requester 1 line write
    req_valid = 2'b10; req_addr[127:64] = 64'h2040; req_write = 2'b10;
    tick;
    chk("wr_ready", req_ready, 2'b10);
    chk("wr_addr", bus_req, 64'h2040);
    chk("wr_tag", bus_reqtag, 13'h1101);
    req_valid = 2'b00; bus_reqack = 1'b1;
    tick;
    bus_reqack = 1'b0;
    chk("wr_reqcyc_drop", bus_reqcyc, 0);
    for (int i = 0; i < 8; i++) begin
      wdata[127:64] = 64'hD0 + 64'(i);
      #1;
      chk("wr_beat", bus_req, 64'hD0 + 64'(i));
      chk("wr_ready_pulse", wdata_ready, 2'b10);
      tick;
    end
    chk("wr_done_ready", wdata_ready, 2'b00);
    chk("wr_idle", dbg_state, 0);
    chk("wr_no_err", err_unexpected, 0);

    // Both requesters continuously valid; last grant was requester 1
    req_valid = 2'b11; req_write = 2'b11; bus_reqack = 1'b1;
    for (int g = 0; g < 4; g++) begin
      k = 0;
      while (req_ready == 2'b00 && k < 20) begin
        tick;
        k++;
      end
      chk("tie_wait_bound", 64'(k < 20), 1);
      chk("tie_round_robin", req_ready, (g % 2 == 0) ? 2'b01 : 2'b10);
      chk("tie_data_prio", req_ready_p, 2'b10);
      if (g == 3) req_valid = 2'b00;
      tick;
    end
    k = 0;
    while (dbg_state != 3'd0 && k < 20) begin
      tick;
      k++;
    end
    chk("tie_drain_bound", 64'(k < 20), 1);
    bus_reqack = 1'b0;
    chk("tie_no_err", err_unexpected, 0);

    // reqack held off for five cycles, requester keeps a second request pending
    req_valid = 2'b01; req_addr[63:0] = 64'h3000; req_write = 2'b00;
    tick;
    chk("stall_first_ready", req_ready, 2'b01);
    for (int c = 2; c <= 6; c++) begin
      tick;
      chk("stall_reqcyc", bus_reqcyc, 1);
      chk("stall_addr", bus_req, 64'h3000);
      chk("stall_tag", bus_reqtag, 13'h0100);
      chk("stall_no_regrant", req_ready, 2'b00);
    end
    req_valid = 2'b00; bus_reqack = 1'b1;
    tick;
    bus_reqack = 1'b0;
    chk("stall_reqcyc_drop", bus_reqcyc, 0);

    // Response ends after three beats
    bus_respcyc = 1'b1; bus_resptag = 13'h0100;
    for (int i = 0; i < 3; i++) begin
      bus_resp = 64'hE0 + 64'(i);
      tick;
      chk("short_valid", resp_valid, 2'b01);
      chk("short_data", resp_data, 64'hE0 + 64'(i));
    end
    bus_respcyc = 1'b0;
    tick;
    chk("short_err", err_unexpected, 1);
    chk("short_idle", dbg_state, 0);
    chk("short_valid_off", resp_valid, 2'b00);
    do_reset;
    chk("reset_clears_err", err_unexpected, 0);

    // Stray response while idle
    bus_respcyc = 1'b1; bus_resptag = 13'h0100; bus_resp = 64'h55;
    #1 chk("stray_respack", bus_respack, 1);
    tick;
    bus_respcyc = 1'b0;
    chk("stray_err", err_unexpected, 1);
    chk("stray_dropped", resp_valid, 2'b00);
    chk("stray_idle", dbg_state, 0);
    do_reset;

    // Mis-tagged beat in RWAIT, then a proper read interrupted by reset
    req_valid = 2'b01; req_addr[63:0] = 64'h4000; req_write = 2'b00;
    tick;
    req_valid = 2'b00; bus_reqack = 1'b1;
    tick;
    bus_reqack = 1'b0;
    bus_respcyc = 1'b1; bus_resptag = 13'h0101; bus_resp = 64'hBB;
    #1 chk("mistag_respack", bus_respack, 1);
    tick;
    chk("mistag_dropped", resp_valid, 2'b00);
    chk("mistag_err", err_unexpected, 1);
    chk("mistag_still_rwait", dbg_state, 3);
    bus_resptag = 13'h0100;
    for (int i = 0; i < 5; i++) begin
      bus_resp = 64'hC0 + 64'(i);
      tick;
      chk("pre_reset_valid", resp_valid, 2'b01);
      chk("pre_reset_data", resp_data, 64'hC0 + 64'(i));
    end
    reset_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_wdata_ready", wdata_ready, 0);
    chk("mid_rst_resp_valid", resp_valid, 0);
    chk("mid_rst_resp_data", resp_data, 0);
    chk("mid_rst_reqcyc", bus_reqcyc, 0);
    chk("mid_rst_req", bus_req, 0);
    chk("mid_rst_reqtag", bus_reqtag, 0);
    chk("mid_rst_err", err_unexpected, 0);
    chk("mid_rst_state", dbg_state, 0);
    bus_respcyc = 1'b0;
    tick;
    reset_n = 1'b1;
    tick;

    read_line(64'h5008, 64'h5000, 64'h70);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
